// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

    // Access size as encoded on req_size
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

    // Natural alignment: halves on even addresses, words on multiples of 4.
    // The illegal size is never considered aligned so it folds into the error path.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input size_e size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~addr_lo[0];
            SZ_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between 32-bit storage words and right-aligned load/store data.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
//
// Ports:
//   rd_word     - storage word containing the addressed bytes (little-endian)
//   offset      - byte offset of the access within that word
//   size        - access size
//   ld_unsigned - zero-extend byte/half loads instead of sign-extending
//   wdata       - right-aligned store data
//   ld_data     - extended load result
//   wr_be       - byte enables for the store
//   wr_data     - store data shifted into its byte lanes
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data
);

    logic [4:0]  bit_off;
    logic [31:0] shifted;

    assign bit_off = {offset, 3'b000};
    // Bring the addressed byte down to lane 0 so byte/half extraction is offset-free
    assign shifted = rd_word >> bit_off;
    assign wr_data = wdata << bit_off;

    always_comb begin
        ld_data = '0;
        wr_be   = '0;
        case (size)
            SZ_B: begin
                ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
                wr_be   = 4'b0001 << offset;
            end
            SZ_H: begin
                ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
                wr_be   = 4'b0011 << offset;
            end
            SZ_W: begin
                ld_data = rd_word;
                wr_be   = 4'b1111;
            end
            default: begin
                ld_data = '0;
                wr_be   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on local byte storage at BASE_ADDR.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle; one request outstanding.
// Backpressure: req_ready low from accept until the response handshake; response held while rsp_ready low.
//
// Ports:
//   clk, reset            - clock; asynchronous active-low reset
//   req_valid/req_ready   - request handshake
//   req_addr, req_we, req_size, req_unsigned, req_wdata - request fields
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_err    - load result (0 for stores and faults), access fault flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(DMEM_BASE_ADDR),
    parameter int                MEM_DEPTH = 1048576,
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IW    = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    // One extra bit on the range arithmetic so addresses near the top of the map cannot wrap
    localparam logic [AWIDTH:0] BASE_X  = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0] DEPTH_X = (AWIDTH + 1)'(MEM_DEPTH);

    logic [7:0] mem [MEM_DEPTH];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata_q;
    logic             err_q;

    logic             accept;
    logic [AWIDTH:0]  addr_x;
    logic [AWIDTH:0]  off_x;
    logic             in_range;
    logic             acc_err;
    size_e            size;
    logic [IW-1:0]    word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;

    assign addr_x   = {1'b0, req_addr};
    assign off_x    = addr_x - BASE_X;
    assign in_range = (addr_x >= BASE_X) && (off_x < DEPTH_X);
    assign size     = size_e'(req_size);
    assign acc_err  = !in_range || !is_aligned(req_addr[1:0], size);

    // Out-of-range requests still index somewhere harmless; their result is discarded
    assign word_idx = in_range ? {off_x[IW-1:2], 2'b00} : '0;

    assign rd_word = {mem[word_idx + IW'(3)], mem[word_idx + IW'(2)],
                      mem[word_idx + IW'(1)], mem[word_idx]};

    // Gated by reset so a request presented during reset cannot commit a store
    assign accept = req_valid && req_ready && reset;

    dmem_lane_align u_lane_align (
        .rd_word     (rd_word),
        .offset      (off_x[1:0]),
        .size        (size),
        .ld_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .ld_data     (ld_data),
        .wr_be       (wr_be),
        .wr_data     (wr_data)
    );

    // Stores commit on the accept edge; storage is never cleared
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx + IW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Load data is captured at accept so request inputs are free afterwards
            if (accept) begin
                rdata_q <= (acc_err || req_we) ? '0 : ld_data;
                err_q   <= acc_err;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port; the core is the initiator.
- Accepts one request at a time over a valid/ready request channel, performs a byte/half/word access on internal little-endian byte storage, and returns read data or an error after a fixed latency over a valid/ready response channel.
- Sits between the core's memory stage and the data memory image, mapped at BASE_ADDR.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width (fixed at 32; other values unsupported)
BASE_ADDR, 32'h01000000, first byte address served
MEM_DEPTH, 1048576, size in bytes (multiple of 4)
LATENCY, 2, cycles from request accept to rsp_valid (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
req_valid  input  1  request present
req_ready  output  1  responder can accept
req_addr  input  AWIDTH  byte address
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends (LBU/LHU)
req_wdata  input  DWIDTH  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  initiator takes response
rsp_rdata  output  DWIDTH  load result, extended; 0 for stores/errors
rsp_err  output  1  access fault

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Storage is not cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the request, go to WAIT (LATENCY>1) or RESP (LATENCY==1).
  - WAIT: counter loads LATENCY-2 at accept and decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1, outputs held stable; on rsp_ready, go to IDLE.
- req_ready=0 in WAIT and RESP. One outstanding request. Minimum spacing between accepts is LATENCY+1 cycles.
- Timing: rsp_valid rises exactly LATENCY cycles after the accept edge, and stays high until the rsp_ready handshake even if rsp_ready is low for many cycles.
- Access commit: stores and load reads both happen on the accept edge. The load result is registered, so request inputs may change freely after accept.
- Range check: in_range = addr>=BASE_ADDR && addr-BASE_ADDR < MEM_DEPTH. Compute in AWIDTH+1 bits so no wrap near 32'hFFFFFFFF.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- Error cases: out of range, misaligned, or req_size=11 → rsp_err=1, rsp_rdata=0, no storage modified, normal latency/handshake.
- Loads: bytes selected by addr offset, little-endian. Byte/half are sign-extended from bit 7/15 unless req_unsigned. Word ignores req_unsigned.
- Stores: write only the addressed byte lanes from req_wdata[7:0]/[15:0]/[31:0]. rsp_rdata=0, rsp_err=0.
- Reset asserted mid-operation: immediately returns to IDLE, rsp_valid=0. An in-flight store already committed at accept stays committed. The pending response is discarded.
- rsp_ready while not rsp_valid: ignored.

Decomposition:
- Package dmem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_ILL)
  - state_e enum (IDLE, WAIT, RESP)
  - BASE_ADDR default constant
  - function is_aligned(addr, size)
- Sub-module dmem_lane_align (combinational):
  - load extraction and sign/zero extension from a 32-bit word plus offset
  - store byte-enable and shifted write-data generation
- The FSM, counter and storage live in dmem_responder.

Test Plan:
- Word store then load at 32'h01000010, wdata 32'hDEADBEEF, LATENCY=2 → store rsp_valid 2 cycles after accept with err=0; load rsp_rdata=32'hDEADBEEF.
- Byte load at 32'h01000011, signed and unsigned, after the above store → rsp_rdata 32'hFFFFFFBE then 32'h000000BE. Half load at 32'h01000012 signed → 32'hFFFFDEAD.
- Misaligned word load at 32'h01000002, and load at 32'h00FFFFFC and 32'h01000000+MEM_DEPTH → rsp_err=1, rsp_rdata=0. A misaligned store (SH at 32'h01000011, wdata 32'h1234) leaves memory unchanged; verify by reading back 32'hDEADBEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid stays 1, rsp_rdata stable, req_ready=0 throughout. Complete the handshake → req_ready=1 the next cycle.
- Async reset asserted while in WAIT during a load → rsp_valid=0 and req_ready=1 immediately, without a clock edge. No response follows after reset release.
- LATENCY=1 build: back-to-back requests with req_valid held high → accepts on cycles 0, 2, 4, with rsp_valid on cycles 1, 3, 5 when rsp_ready=1.
